// File: rtl/pass_hls_deadlock_report_unit_if.sv
// rtl/pass_hls_deadlock_report_unit_if.sv - signal bundle between the detect units/host and the deadlock report unit
interface pass_hls_deadlock_report_unit_if #(
   parameter int PROC_NUM  = 4,
   parameter int CNT_WIDTH = 16
);
   localparam int IDX_W = $clog2(PROC_NUM);

   logic [PROC_NUM-1:0]  dl_detect_vec;
   logic [PROC_NUM-1:0]  token_seen_vec;
   logic                 dl_ack;
   logic [PROC_NUM-1:0]  origin_vec;
   logic [PROC_NUM-1:0]  token_clear_vec;
   logic                 dl_detect_in;
   logic                 dl_valid;
   logic [PROC_NUM-1:0]  dl_proc_vec;
   logic [IDX_W-1:0]     dl_origin_idx;
   logic [CNT_WIDTH-1:0] dl_trace_cycles;
   logic                 dl_timeout;

   modport slave (
      input  dl_detect_vec, token_seen_vec, dl_ack,
      output origin_vec, token_clear_vec, dl_detect_in, dl_valid,
             dl_proc_vec, dl_origin_idx, dl_trace_cycles, dl_timeout
   );

   modport master (
      output dl_detect_vec, token_seen_vec, dl_ack,
      input  origin_vec, token_clear_vec, dl_detect_in, dl_valid,
             dl_proc_vec, dl_origin_idx, dl_trace_cycles, dl_timeout
   );
endinterface

// File: rtl/pass_hls_deadlock_report_unit.sv
// rtl/pass_hls_deadlock_report_unit.sv - deadlock origin picker, token tracer and latched report
// Optional simulation-only report print and origin one-hot check: PASS_HLS_DEADLOCK_REPORT_DISPLAY_EN
module pass_hls_deadlock_report_unit #(
   parameter int PROC_NUM      = 4,
   parameter int TRACE_TIMEOUT = 256,
   parameter int CNT_WIDTH     = 16
) (
   input logic clock,
   input logic reset,
   pass_hls_deadlock_report_unit_if.slave dl_if
);
   localparam int IDX_W = $clog2(PROC_NUM);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TRACE_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ORIGIN, TRACE, REPORT} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     origin_idx_q, origin_idx_d;
   logic [PROC_NUM-1:0]  origin_vec_q, origin_vec_d;
   logic [PROC_NUM-1:0]  proc_vec_q, proc_vec_d;
   logic [CNT_WIDTH-1:0] trace_cnt_q, trace_cnt_d;
   logic                 detect_in_q, detect_in_d;
   logic                 valid_q, valid_d;
   logic                 timeout_q, timeout_d;

   logic [IDX_W-1:0]     low_idx;
   logic                 any_detect;
   logic                 trace_return;
   logic                 trace_expire;
   logic [PROC_NUM-1:0]  token_clear;

   // Lowest set index wins when several units report in the same cycle
   always_comb begin
      low_idx = '0;
      for (int p = PROC_NUM - 1; p >= 0; p--) begin
         if (dl_if.dl_detect_vec[p]) low_idx = IDX_W'(p);
      end
   end

   assign any_detect   = |dl_if.dl_detect_vec;
   assign trace_return = dl_if.dl_detect_vec[origin_idx_q] & dl_if.token_seen_vec[origin_idx_q];
   assign trace_expire = (trace_cnt_q == CNT_LAST);

   always_comb begin
      state_d      = state_q;
      origin_idx_d = origin_idx_q;
      origin_vec_d = origin_vec_q;
      proc_vec_d   = proc_vec_q;
      trace_cnt_d  = trace_cnt_q;
      detect_in_d  = detect_in_q;
      valid_d      = valid_q;
      timeout_d    = timeout_q;
      token_clear  = '0;
      case (state_q)
         IDLE: begin
            detect_in_d = 1'b0;
            if (any_detect) begin
               origin_idx_d = low_idx;
               origin_vec_d = PROC_NUM'(1) << low_idx;
               proc_vec_d   = PROC_NUM'(1) << low_idx;
               detect_in_d  = 1'b1;
               trace_cnt_d  = '0;
               timeout_d    = 1'b0;
               state_d      = ORIGIN;
            end
         end
         ORIGIN: begin
            origin_vec_d = '0;
            state_d      = TRACE;
         end
         TRACE: begin
            proc_vec_d  = proc_vec_q | dl_if.token_seen_vec;
            trace_cnt_d = trace_cnt_q + CNT_WIDTH'(1);
            // A return in the final allowed cycle still counts as a clean return
            if (trace_return) begin
               token_clear = PROC_NUM'(1) << origin_idx_q;
               valid_d     = 1'b1;
               timeout_d   = 1'b0;
               state_d     = REPORT;
            end else if (trace_expire) begin
               valid_d   = 1'b1;
               timeout_d = 1'b1;
               state_d   = REPORT;
            end
         end
         REPORT: begin
            if (dl_if.dl_ack) begin
               valid_d     = 1'b0;
               detect_in_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         origin_idx_q <= '0;
         origin_vec_q <= '0;
         proc_vec_q   <= '0;
         trace_cnt_q  <= '0;
         detect_in_q  <= 1'b0;
         valid_q      <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         origin_idx_q <= origin_idx_d;
         origin_vec_q <= origin_vec_d;
         proc_vec_q   <= proc_vec_d;
         trace_cnt_q  <= trace_cnt_d;
         detect_in_q  <= detect_in_d;
         valid_q      <= valid_d;
         timeout_q    <= timeout_d;
      end
   end

   assign dl_if.origin_vec      = origin_vec_q;
   assign dl_if.token_clear_vec = token_clear;
   assign dl_if.dl_detect_in    = detect_in_q;
   assign dl_if.dl_valid        = valid_q;
   assign dl_if.dl_proc_vec     = proc_vec_q;
   assign dl_if.dl_origin_idx   = origin_idx_q;
   assign dl_if.dl_trace_cycles = trace_cnt_q;
   assign dl_if.dl_timeout      = timeout_q;

`ifdef PASS_HLS_DEADLOCK_REPORT_DISPLAY_EN
   always @(posedge clock) begin
      if (reset && state_q == TRACE && state_d == REPORT) begin
         $display("%0t deadlock report: origin=%0d procs=%b cycles=%0d%s", $time,
                  origin_idx_q, proc_vec_d, trace_cnt_d, timeout_d ? " TIMEOUT" : "");
      end
      if (reset) begin
         assert ($onehot0(origin_vec_q)) else $error("origin_vec not one-hot: %b", origin_vec_q);
      end
   end
`endif
endmodule

// File: tb/tb_pass_hls_deadlock_report_unit.sv
// tb/tb_pass_hls_deadlock_report_unit.sv - randomized self-checking bench for the deadlock report unit
module tb_pass_hls_deadlock_report_unit;
   localparam int PROC_NUM      = 4;
   localparam int TRACE_TIMEOUT = 8;
   localparam int CNT_WIDTH     = 16;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int failures = 0;
   string cur_case = "reset";
   logic [3:0] seen_tab [0:15];

   pass_hls_deadlock_report_unit_if #(.PROC_NUM(PROC_NUM), .CNT_WIDTH(CNT_WIDTH)) dl_if ();

   pass_hls_deadlock_report_unit #(
      .PROC_NUM(PROC_NUM), .TRACE_TIMEOUT(TRACE_TIMEOUT), .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clock(clock),
      .reset(reset),
      .dl_if(dl_if)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s/%s observed=0x%0h expected=0x%0h", cur_case, tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic fill_seen_random();
      for (int i = 0; i < 16; i++) seen_tab[i] = 4'($urandom);
   endtask

   task automatic drive(input logic [3:0] dv, input logic [3:0] sv, input logic ack);
      dl_if.dl_detect_vec  = dv;
      dl_if.token_seen_vec = sv;
      dl_if.dl_ack         = ack;
   endtask

   // Model: origin = lowest detect bit, report set = origin plus every token seen,
   // trace length = return cycle or TRACE_TIMEOUT, timeout only without a return.
   task automatic run_case(input string name, input logic [3:0] det, input int ret_at);
      int org;
      int exp_cyc;
      logic [3:0] ob;
      logic [3:0] exp_proc;
      logic [3:0] dv;
      logic [3:0] sv;
      cur_case = name;
      org = lowest(det);
      ob = 4'b0001 << org;
      chk("idle_valid", 32'(dl_if.dl_valid), 0);
      drive(det, 4'($urandom), 1'b0);
      #1;
      chk("idle_clear", 32'(dl_if.token_clear_vec), 0);
      step();
      drive(4'b0, 4'b0, 1'b0);
      chk("origin_vec", 32'(dl_if.origin_vec), 32'(ob));
      chk("origin_idx", 32'(dl_if.dl_origin_idx), 32'(org));
      chk("origin_detect_in", 32'(dl_if.dl_detect_in), 1);
      step();
      chk("origin_vec_drop", 32'(dl_if.origin_vec), 0);
      chk("trace_detect_in", 32'(dl_if.dl_detect_in), 1);
      exp_proc = ob;
      exp_cyc = TRACE_TIMEOUT;
      for (int c = 1; c <= TRACE_TIMEOUT; c++) begin
         if (c == ret_at) begin
            dv = 4'($urandom) | ob;
            sv = seen_tab[c-1] | ob;
         end else begin
            dv = 4'($urandom) & ~ob;
            sv = seen_tab[c-1];
         end
         drive(dv, sv, 1'($urandom));
         exp_proc = exp_proc | sv;
         #1;
         chk("trace_clear", 32'(dl_if.token_clear_vec), (c == ret_at) ? 32'(ob) : 0);
         step();
         if (c == ret_at) begin
            exp_cyc = c;
            break;
         end
      end
      drive(ob, ob, 1'b0);
      #1;
      chk("report_valid", 32'(dl_if.dl_valid), 1);
      chk("report_timeout", 32'(dl_if.dl_timeout), (ret_at == 0) ? 1 : 0);
      chk("report_cycles", 32'(dl_if.dl_trace_cycles), 32'(exp_cyc));
      chk("report_procs", 32'(dl_if.dl_proc_vec), 32'(exp_proc));
      chk("report_idx", 32'(dl_if.dl_origin_idx), 32'(org));
      chk("report_detect_in", 32'(dl_if.dl_detect_in), 1);
      chk("report_clear", 32'(dl_if.token_clear_vec), 0);
      step();
      drive(4'b0, 4'b0, 1'b0);
      chk("report_hold_valid", 32'(dl_if.dl_valid), 1);
      chk("report_hold_procs", 32'(dl_if.dl_proc_vec), 32'(exp_proc));
      dl_if.dl_ack = 1'b1;
      step();
      dl_if.dl_ack = 1'b0;
      chk("ack_valid", 32'(dl_if.dl_valid), 0);
      chk("ack_detect_in", 32'(dl_if.dl_detect_in), 0);
      chk("ack_procs_kept", 32'(dl_if.dl_proc_vec), 32'(exp_proc));
      chk("ack_origin_vec", 32'(dl_if.origin_vec), 0);
      step();
      chk("idle_again", 32'(dl_if.dl_detect_in), 0);
   endtask

   initial begin
      drive(4'b0, 4'b0, 1'b0);
      reset = 1'b0;
      step();
      step();
      chk("rst_valid", 32'(dl_if.dl_valid), 0);
      chk("rst_detect_in", 32'(dl_if.dl_detect_in), 0);
      chk("rst_origin_vec", 32'(dl_if.origin_vec), 0);
      chk("rst_procs", 32'(dl_if.dl_proc_vec), 0);
      chk("rst_idx", 32'(dl_if.dl_origin_idx), 0);
      chk("rst_cycles", 32'(dl_if.dl_trace_cycles), 0);
      chk("rst_timeout", 32'(dl_if.dl_timeout), 0);
      chk("rst_clear", 32'(dl_if.token_clear_vec), 0);
      reset = 1'b1;
      step();

      cur_case = "reset_mid_trace";
      drive(4'b0100, 4'b0, 1'b0);
      step();
      drive(4'b0, 4'b0, 1'b0);
      chk("origin_vec", 32'(dl_if.origin_vec), 32'h4);
      step();
      repeat (5) step();
      chk("detect_in_before", 32'(dl_if.dl_detect_in), 1);
      dl_if.token_seen_vec = 4'b1011;
      #2 reset = 1'b0;
      #1;
      chk("async_detect_in", 32'(dl_if.dl_detect_in), 0);
      chk("async_procs", 32'(dl_if.dl_proc_vec), 0);
      chk("async_idx", 32'(dl_if.dl_origin_idx), 0);
      chk("async_clear", 32'(dl_if.token_clear_vec), 0);
      dl_if.token_seen_vec = 4'b0;
      step();
      reset = 1'b1;
      step();
      chk("post_valid", 32'(dl_if.dl_valid), 0);
      chk("post_origin_vec", 32'(dl_if.origin_vec), 0);
      fill_seen_random();
      run_case("restart", 4'b0100, 3);

      seen_tab[0] = 4'b0100;
      seen_tab[1] = 4'b0000;
      run_case("two_proc", 4'b0010, 2);
      chk("two_proc_procs", 32'(dl_if.dl_proc_vec), 32'h6);
      chk("two_proc_cycles", 32'(dl_if.dl_trace_cycles), 2);

      fill_seen_random();
      run_case("simultaneous", 4'b1010, 3);
      chk("simul_idx", 32'(dl_if.dl_origin_idx), 1);

      fill_seen_random();
      run_case("timeout", 4'($urandom_range(1, 15)), 0);
      chk("timeout_cycles", 32'(dl_if.dl_trace_cycles), 8);
      chk("timeout_flag", 32'(dl_if.dl_timeout), 1);

      fill_seen_random();
      run_case("return_at_limit", 4'($urandom_range(1, 15)), TRACE_TIMEOUT);
      chk("limit_flag", 32'(dl_if.dl_timeout), 0);

      for (int n = 0; n < 8; n++) begin
         fill_seen_random();
         run_case($sformatf("random%0d", n), 4'($urandom_range(1, 15)),
                  $urandom_range(0, TRACE_TIMEOUT));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
